div_unit: RTL and testbench

Parametrised multi-cycle restoring divider for the OpenMIPS execute stage, producing quotient and remainder for DIV/DIVU into HI/LO. The pipeline gets its first multi-cycle operation and its first start/ready handshake. EX holds `start_i` and stalls the pipeline until `ready_o`. Operand width is generic, so the same block serves 32-bit and narrower datapath variants.

---
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) with start/ready handshake, result = {remainder, quotient}.
// Define DIV_SIGNED_EN to include the signed (DIV) path; without it every operation is unsigned.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH:0]     shreg_q, shreg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_mag, op2_mag;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     quot, rem, quot_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    assign op1_neg = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_i & opdata2_i[WIDTH-1];
`else
    logic unused_signed;
    assign unused_signed = signed_i;
    assign op1_neg = 1'b0;
    assign op2_neg = 1'b0;
`endif

    // Magnitudes stay WIDTH-bit unsigned so the most negative operand maps to 2^(WIDTH-1).
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    assign trial    = {1'b0, shreg_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
    assign quot     = shreg_q[WIDTH-1:0];
    assign rem      = shreg_q[2*WIDTH:WIDTH+1];
    assign quot_fix = neg_quot_q ? -quot : quot;
    assign rem_fix  = neg_rem_q  ? -rem  : rem;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BY_ZERO;
                    end else begin
                        state_d    = ON;
                        shreg_d    = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                        divisor_d  = op2_mag;
                        cnt_d      = '0;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end
            BY_ZERO: begin
                state_d  = END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_d    = FREE;
                    shreg_d    = '0;
                    cnt_d      = '0;
                    divisor_d  = '0;
                    neg_quot_d = 1'b0;
                    neg_rem_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end else begin
                    shreg_d = trial[WIDTH] ? {shreg_q[2*WIDTH-1:0], 1'b0}
                                           : {trial[WIDTH-1:0], shreg_q[WIDTH-1:0], 1'b1};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH=32): directed table, handshake corner cases, random vs. model.
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Truncating division in 64-bit arithmetic; the wrap of MIN/-1 falls out of the 32-bit slice.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Starts at a negedge; operands are scrambled after the start edge to prove they are ignored.
    task automatic do_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold);
        int lat;
        int exp_lat;
        logic [63:0] res;
        exp_lat   = (b == 32'h0) ? 2 : W + 2;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        start_i   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom);
        end while (!ready_o && lat < 200);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, result_o, exp);
        res = result_o;
        for (int i = 0; i < hold; i++) begin
            annul_i = 1'($urandom);
            @(negedge clk);
            chk({name, " hold ready"}, 64'(ready_o), 64'h1);
            chk({name, " hold result"}, result_o, res);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk({name, " drop ready"}, 64'(ready_o), 64'h0);
        chk({name, " drop result"}, result_o, 64'h0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 0};
        tbl[1] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 0};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         64'h0000000F_0FFFFFFF, 2};
        tbl[3] = '{1'b0, 32'd5,          32'd0,          64'h0,                 0};
        tbl[4] = '{1'b0, 32'd0,          32'd5,          64'h0,                 0};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 1};
`ifdef DIV_SIGNED_EN
        tbl[6] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 0};
        tbl[7] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 0};
        tbl[8] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 0};
        tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003, 2};
`else
        tbl[6] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC, 0};
        tbl[7] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 0};
        tbl[8] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000007_00000000, 0};
        tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFF9_00000000, 2};
`endif

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset ready", 64'(ready_o), 64'h0);
        chk("reset result", result_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_div($sformatf("tbl%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold);

        // Divide by zero, annul in BY_ZERO and END ignored, outputs stable over a 5-cycle hold.
        signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        chk("dz ready after E0", 64'(ready_o), 64'h0);
        annul_i = 1'b1;
        @(negedge clk);
        chk("dz ready at E1", 64'(ready_o), 64'h1);
        chk("dz result at E1", result_o, 64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dz hold ready", 64'(ready_o), 64'h1);
            chk("dz hold result", result_o, 64'h0);
        end
        annul_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("dz drop ready", 64'(ready_o), 64'h0);

        // Annul sampled at E10 (10th ON cycle), then an immediate new start with start_i kept high.
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("annul busy ready", 64'(ready_o), 64'h0);
        end
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul ready", 64'(ready_o), 64'h0);
        chk("annul result", result_o, 64'h0);
        do_div("annul restart", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);

        // Reset sampled at E20 (20th ON cycle).
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 19; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset ready", 64'(ready_o), 64'h0);
        chk("midreset result", result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0) chk("postreset ready", 64'(ready_o), 64'h0);
        end
        chk("postreset idle ready", 64'(ready_o), 64'h0);
        do_div("after reset", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 0);

        // start and annul together in FREE must not launch anything.
        signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("start+annul ready", 64'(ready_o), 64'h0);
        end
        do_div("after start+annul", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 0);

        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom);
            case ($urandom_range(3))
                0: ra = $urandom;
                1: ra = 32'h8000_0000;
                2: ra = 32'($urandom_range(1000));
                default: ra = 32'hFFFF_FFFF - 32'($urandom_range(20));
            endcase
            case ($urandom_range(4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'h8000_0000;
                default: rb = $urandom >> $urandom_range(31);
            endcase
            do_div($sformatf("rand%0d", n), rs, ra, rb, ref_div(rs, ra, rb), int'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
